hazard_scoreboard: RTL

Parametrised scoreboard-based RAW hazard unit for the in-order pipeline's decode stage, replacing fixed per-stage destination-register comparison. It keeps one countdown counter per architectural register, giving the number of cycles a reader in ID must still wait. It supports forwarding and non-forwarding pipelines of configurable depth, load-use latency and register count. It also tracks in-flight writes and accumulates a stall-cycle statistic.

---
 rtl/hazard_scoreboard.sv | 75 +++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based RAW hazard unit for the decode stage: one countdown per register
// gives the cycles a reader in ID must still wait before it may issue.
module hazard_scoreboard #(
  parameter  int NREG     = 8,
  parameter  int FWD      = 1,
  parameter  int DEPTH    = 2,
  parameter  int ALU_LAT  = 0,
  parameter  int LOAD_LAT = 1,
  localparam int RW       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_ID,
  input  logic [RW-1:0] rs_ID,
  input  logic [RW-1:0] rt_ID,
  input  logic          rs_used_ID,
  input  logic          rt_used_ID,
  input  logic          wr_en_ID,
  input  logic [RW-1:0] wr_reg_ID,
  input  logic          is_load_ID,
  input  logic          flush_ID,
  output logic          stall,
  output logic          busy,
  output logic [15:0]   stall_cnt
);

  localparam int MAX_AL = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int MAXL   = (DEPTH > MAX_AL) ? DEPTH : MAX_AL;
  localparam int CW     = (MAXL < 1) ? 1 : $clog2(MAXL + 1);

  // Without forwarding every producer waits the full pipeline depth.
  localparam logic [CW-1:0] LAT_ALU  = CW'((FWD != 0) ? ALU_LAT  : DEPTH);
  localparam logic [CW-1:0] LAT_LOAD = CW'((FWD != 0) ? LOAD_LAT : DEPTH);

  logic [CW-1:0] cnt [NREG];
  logic          haz_rs;
  logic          haz_rt;
  logic          issue;
  logic [CW-1:0] new_lat;

  always_comb begin
    haz_rs  = rs_used_ID && (cnt[rs_ID] != '0);
    haz_rt  = rt_used_ID && (cnt[rt_ID] != '0);
    stall   = !rst && valid_ID && (haz_rs || haz_rt);
    issue   = valid_ID && !stall && !flush_ID;
    new_lat = is_load_ID ? LAT_LOAD : LAT_ALU;
  end

  // The youngest producer always overwrites its register's counter, even with a smaller value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (issue && wr_en_ID && (wr_reg_ID == RW'(r)))
          cnt[r] <= new_lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - CW'(1);
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NREG; r++) busy = busy | (cnt[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule
